// File: rtl/ace_ps2_keymatrix.sv
// ace_ps2_keymatrix: PS/2 scan-code set 2 keyboard to Jupiter Ace 8x5 key matrix.
// Ports: clk, reset (async, active-low); ps2_clk/ps2_data raw pins; filas row select in and
//   columnas column return out (both active-low); scancode/scancode_valid debug byte strobe;
//   user_reset_n hot-key reset request. Define KBD_HOTKEY_RESET_EN for LCtrl+LAlt+Delete reset.
module ace_ps2_keymatrix #(
  parameter int TIMEOUT_CYCLES = 6500,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] filas,
  output logic [4:0] columnas,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       user_reset_n
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] TMO_MAX  = IW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] TMO_LAST = IW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} dec_state_t;

  // ---------------- input conditioning ----------------
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic clk_prev, fall, din;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign din  = dat_sync[SYNC_STAGES-1];

  // ---------------- frame receiver ----------------
  logic [3:0]    bit_cnt;
  logic [7:0]    sr;
  logic          par;
  logic [IW-1:0] idle_cnt;
  logic          rx_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '0;
      sr       <= '0;
      par      <= 1'b0;
      idle_cnt <= '0;
    end else if (fall) begin
      idle_cnt <= '0;
      case (bit_cnt)
        4'd0:    if (!din) bit_cnt <= 4'd1;   // a high start bit is not a frame
        4'd9:    begin par <= din; bit_cnt <= 4'd10; end
        4'd10:   bit_cnt <= 4'd0;
        default: begin sr <= {din, sr[7:1]}; bit_cnt <= bit_cnt + 4'd1; end
      endcase
    end else begin
      if (idle_cnt != TMO_MAX) idle_cnt <= idle_cnt + 1'b1;
      // Silence on the line means a partial frame is stale: resync to the next start bit.
      if (idle_cnt == TMO_LAST) bit_cnt <= '0;
    end
  end

  // Stop-bit edge with odd parity over data+parity and a high stop bit.
  assign rx_done = fall && (bit_cnt == 4'd10) && din && (^{par, sr});

  // ---------------- decoder ----------------
  dec_state_t st, st_n;
  logic [2:0]  skip, skip_n;
  logic        upd, upd_ext, upd_val;
  logic [39:0] key_map, key_map_n;
  // Second sources for matrix bits that a physical bit already covers.
  logic shift_r, shift_r_n, sym_r, sym_r_n, ent_r, ent_r_n, bksp, bksp_n;
  logic [5:0]  idx;
`ifdef KBD_HOTKEY_RESET_EN
  logic lalt, lalt_n, del, del_n;
`endif

  function automatic logic [5:0] phys_idx(input logic [7:0] code);
    case (code)
      8'h12: return 6'd0;  8'h14: return 6'd1;  8'h1A: return 6'd2;  8'h22: return 6'd3;  8'h21: return 6'd4;
      8'h1C: return 6'd5;  8'h1B: return 6'd6;  8'h23: return 6'd7;  8'h2B: return 6'd8;  8'h34: return 6'd9;
      8'h15: return 6'd10; 8'h1D: return 6'd11; 8'h24: return 6'd12; 8'h2D: return 6'd13; 8'h2C: return 6'd14;
      8'h16: return 6'd15; 8'h1E: return 6'd16; 8'h26: return 6'd17; 8'h25: return 6'd18; 8'h2E: return 6'd19;
      8'h45: return 6'd20; 8'h46: return 6'd21; 8'h3E: return 6'd22; 8'h3D: return 6'd23; 8'h36: return 6'd24;
      8'h4D: return 6'd25; 8'h44: return 6'd26; 8'h43: return 6'd27; 8'h3C: return 6'd28; 8'h35: return 6'd29;
      8'h5A: return 6'd30; 8'h4B: return 6'd31; 8'h42: return 6'd32; 8'h3B: return 6'd33; 8'h33: return 6'd34;
      8'h29: return 6'd35; 8'h3A: return 6'd36; 8'h31: return 6'd37; 8'h32: return 6'd38; 8'h2A: return 6'd39;
      default: return 6'd63;
    endcase
  endfunction

  always_comb begin
    st_n    = st;
    skip_n  = skip;
    upd     = 1'b0;
    upd_ext = 1'b0;
    upd_val = 1'b0;
    if (rx_done) begin
      case (st)
        IDLE: begin
          if (sr == 8'hF0)      st_n = BRK;
          else if (sr == 8'hE0) st_n = EXT;
          else if (sr == 8'hE1) begin st_n = SKIP; skip_n = 3'd7; end
          else begin upd = 1'b1; upd_val = 1'b1; end
        end
        EXT: begin
          if (sr == 8'hF0) st_n = EXTBRK;
          else begin upd = 1'b1; upd_ext = 1'b1; upd_val = 1'b1; st_n = IDLE; end
        end
        BRK:    begin upd = 1'b1; st_n = IDLE; end
        EXTBRK: begin upd = 1'b1; upd_ext = 1'b1; st_n = IDLE; end
        SKIP: begin
          skip_n = skip - 3'd1;
          if (skip == 3'd1) st_n = IDLE;
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_comb begin
    key_map_n = key_map;
    shift_r_n = shift_r;
    sym_r_n   = sym_r;
    ent_r_n   = ent_r;
    bksp_n    = bksp;
`ifdef KBD_HOTKEY_RESET_EN
    lalt_n    = lalt;
    del_n     = del;
`endif
    idx       = phys_idx(sr);
    if (upd) begin
      if (!upd_ext) begin
        if (idx < 6'd40) key_map_n[idx] = upd_val;
        if (sr == 8'h59) shift_r_n = upd_val;
        if (sr == 8'h66) bksp_n    = upd_val;
`ifdef KBD_HOTKEY_RESET_EN
        if (sr == 8'h11) lalt_n    = upd_val;
`endif
      end else begin
        // Extended codes not listed here (fake shifts included) are ignored.
        if (sr == 8'h14) sym_r_n = upd_val;
        if (sr == 8'h5A) ent_r_n = upd_val;
`ifdef KBD_HOTKEY_RESET_EN
        if (sr == 8'h71) del_n   = upd_val;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st             <= IDLE;
      skip           <= '0;
      key_map        <= '0;
      shift_r        <= 1'b0;
      sym_r          <= 1'b0;
      ent_r          <= 1'b0;
      bksp           <= 1'b0;
      scancode       <= 8'h00;
      scancode_valid <= 1'b0;
    end else begin
      st             <= st_n;
      skip           <= skip_n;
      key_map        <= key_map_n;
      shift_r        <= shift_r_n;
      sym_r          <= sym_r_n;
      ent_r          <= ent_r_n;
      bksp           <= bksp_n;
      scancode_valid <= rx_done;
      if (rx_done) scancode <= sr;
    end
  end

  // ---------------- matrix scan ----------------
  logic [39:0] key_mat;
  logic [4:0]  hit;

  always_comb begin
    key_mat     = key_map;
    key_mat[0]  = key_map[0]  | shift_r | bksp;  // SHIFT
    key_mat[1]  = key_map[1]  | sym_r;           // SYMBOL
    key_mat[20] = key_map[20] | bksp;            // 0
    key_mat[30] = key_map[30] | ent_r;           // ENTER
    hit = '0;
    for (int r = 0; r < 8; r++) begin
      if (!filas[r]) hit = hit | key_mat[r*5 +: 5];
    end
  end

  assign columnas = ~hit;

  // ---------------- hot-key reset ----------------
`ifdef KBD_HOTKEY_RESET_EN
  logic       combo, hk_rst;
  logic [9:0] hk_cnt;

  assign combo = key_map[1] & lalt & del;  // LCtrl(14) + LAlt + Delete

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lalt   <= 1'b0;
      del    <= 1'b0;
      hk_cnt <= '0;
      hk_rst <= 1'b0;
    end else begin
      lalt   <= lalt_n;
      del    <= del_n;
      if (combo)              hk_cnt <= 10'h3FF;
      else if (hk_cnt != '0)  hk_cnt <= hk_cnt - 10'd1;
      hk_rst <= combo | (hk_cnt != '0);
    end
  end

  assign user_reset_n = ~hk_rst;
`else
  assign user_reset_n = 1'b1;
`endif

endmodule

// File: tb/tb_ace_ps2_keymatrix.sv
module tb_ace_ps2_keymatrix;
  localparam int TMO = 6500;
  localparam int HP  = 12;   // PS/2 clock half period in core clocks

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] filas = 8'hFF;
  logic [4:0] columnas;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       user_reset_n;

  always #5 clk = ~clk;

  ace_ps2_keymatrix #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .filas(filas),
    .columnas(columnas), .scancode(scancode), .scancode_valid(scancode_valid),
    .user_reset_n(user_reset_n)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [7:0] code; logic [4:0] cols; } exp_t;
  exp_t exp_q[$];

  // Reference model: set of held keys (ext keys offset by 256) plus prefix tracking.
  bit held[int];
  int m_ext = 0, m_brk = 0, m_skip = 0;
  int pool[$];

  logic [7:0] phys_tab [40] = '{
    8'h12, 8'h14, 8'h1A, 8'h22, 8'h21,   8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,   8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,   8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,   8'h29, 8'h3A, 8'h31, 8'h32, 8'h2A};

  function automatic logic [4:0] model_cols(input logic [7:0] f);
    logic [4:0] h;
    h = '0;
    for (int r = 0; r < 8; r++) begin
      if (!f[r]) begin
        for (int c = 0; c < 5; c++) begin
          bit on;
          on = held.exists(int'(phys_tab[r*5+c]));
          if (r == 0 && c == 0 && (held.exists('h59) || held.exists('h66))) on = 1;
          if (r == 0 && c == 1 && held.exists('h114)) on = 1;
          if (r == 4 && c == 0 && held.exists('h66)) on = 1;
          if (r == 6 && c == 0 && held.exists('h15A)) on = 1;
          if (on) h[c] = 1'b1;
        end
      end
    end
    return ~h;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int k;
    k = (m_ext != 0 ? 256 : 0) + int'(b);
    if (m_skip > 0) m_skip--;
    else if (m_brk != 0) begin
      if (held.exists(k)) held.delete(k);
      m_brk = 0; m_ext = 0;
    end
    else if (b == 8'hF0) m_brk = 1;
    else if (m_ext != 0) begin held[k] = 1; m_ext = 0; end
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hE1) m_skip = 7;
    else held[k] = 1;
  endfunction

  function automatic void model_reset();
    held.delete();
    m_ext = 0; m_brk = 0; m_skip = 0;
  endfunction

  function automatic logic [10:0] frame(input logic [7:0] b, input bit badp);
    return {1'b1, (~^b) ^ badp, b, 1'b0};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      tick(HP); ps2_clk = 1'b0;
      tick(HP); ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_t e;
    model_byte(b);
    e.code = b;
    e.cols = model_cols(filas);
    exp_q.push_back(e);
    ps2_bits(frame(b, 1'b0), 11);
  endtask

  task automatic send_key(input int k, input bit brk);
    if (k >= 256) send_byte(8'hE0);
    if (brk) send_byte(8'hF0);
    send_byte(8'(k));
  endtask

  task automatic check_cols(input logic [7:0] f);
    filas = f;
    #1;
    check("columnas", {3'b0, columnas}, {3'b0, model_cols(f)});
  endtask

  // Monitor: every strobe must match the oldest outstanding byte.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (scancode_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_strobe: scancode %h, expected no strobe", scancode);
        end else begin
          e = exp_q.pop_front();
          check("scancode", scancode, e.code);
          check("strobe_cols", {3'b0, columnas}, {3'b0, e.cols});
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    logic hk_exp;
    for (int i = 0; i < 40; i++) pool.push_back(int'(phys_tab[i]));
    pool.push_back('h59); pool.push_back('h66); pool.push_back('h114); pool.push_back('h15A);
    pool.push_back('h112); pool.push_back('h159); pool.push_back('h171);
    pool.push_back('h0D); pool.push_back('h76); pool.push_back('h175);

    // Reset with random rows selected.
    filas = 8'($urandom);
    tick(3);
    check("rst_columnas", {3'b0, columnas}, 8'h1F);
    check("rst_valid", {7'b0, scancode_valid}, 8'h00);
    check("rst_scancode", scancode, 8'h00);
    check("rst_user_reset_n", {7'b0, user_reset_n}, 8'h01);
    filas = 8'h00;
    #1 check("rst_columnas_all_rows", {3'b0, columnas}, 8'h1F);
    reset = 1'b1;
    tick(5);

    // Z make and break on row 0.
    filas = 8'hFE;
    send_byte(8'h1A);
    check_cols(8'hFE);
    send_byte(8'hF0); send_byte(8'h1A);
    check_cols(8'hFE);

    // SHIFT plus Backspace; releasing Backspace keeps SHIFT.
    send_key('h12, 0); send_key('h66, 0);
    check_cols(8'hEF);
    send_key('h66, 1);
    check_cols(8'hFE);
    check_cols(8'hEF);
    send_key('h12, 1);
    check_cols(8'h00);

    // Bad parity frame is dropped.
    filas = 8'hFD;
    ps2_bits(frame(8'h1C, 1'b1), 11);
    check_cols(8'hFD);
    // Partial frame then idle timeout, then a clean A.
    ps2_bits(frame(8'h1C, 1'b0), 6);
    tick(TMO + 1);
    send_byte(8'h1C);
    check_cols(8'hFD);
    send_key('h1C, 1);

    // SPACE and V share row 7; then all rows with SPACE alone.
    send_key('h29, 0); send_key('h2A, 0);
    check_cols(8'h7F);
    send_key('h2A, 1);
    check_cols(8'h00);
    send_key('h29, 1);
    check_cols(8'h00);

    // Randomised key traffic, including Pause and releases of keys not held.
    for (int ev = 0; ev < 40; ev++) begin
      filas = 8'($urandom);
      if ($urandom_range(11) == 0) begin
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
      end else begin
        int k;
        k = pool[$urandom_range(pool.size() - 1)];
        send_key(k, held.exists(k) ? ($urandom_range(3) != 0) : ($urandom_range(4) == 0));
      end
      check_cols(8'($urandom));
      check_cols(8'h00);
    end

    // Make sure something is held, then reset in the middle of a frame.
    send_key('h15, 0);
    filas = 8'hFF;
    ps2_bits(frame(8'h16, 1'b0), 4);
    reset = 1'b0;
    tick(2);
    model_reset();
    check_cols(8'h00);
    reset = 1'b1;
    tick(5);
    filas = 8'hF7;
    send_byte(8'h16);
    check_cols(8'hF7);
    send_key('h16, 1);

    // Hot-key combination.
`ifdef KBD_HOTKEY_RESET_EN
    hk_exp = 1'b0;
`else
    hk_exp = 1'b1;
`endif
    send_key('h14, 0); send_key('h11, 0); send_key('h171, 0);
    tick(4);
    check("hotkey_held", {7'b0, user_reset_n}, {7'b0, hk_exp});
    send_key('h171, 1);
    tick(1000);
    check("hotkey_hold_1000", {7'b0, user_reset_n}, {7'b0, hk_exp});
    tick(100);
    check("hotkey_released", {7'b0, user_reset_n}, 8'h01);
    send_key('h11, 1); send_key('h14, 1);
    check_cols(8'h00);

    tick(50);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_strobes: %0d outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
